// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle adder/logic ops plus multi-cycle
// shift-add multiply behind a Start/Busy/Done handshake.
// Optional restoring divider (UDIV/SDIV) is built only when ALU_DIV_EN is defined.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] Src_A,
  input  logic [WIDTH-1:0] Src_B,
  input  logic             C_Flag,
  input  logic             isArithmeticOp,
  input  logic             isADC,
  input  logic             Shifter_carryOut,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ALUResultHi,
  output logic [3:0]       ALUFlags
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_ORR   = 4'b0011;
  localparam logic [3:0] OP_EOR   = 4'b0100;
  localparam logic [3:0] OP_RSB   = 4'b0101;
  localparam logic [3:0] OP_BIC   = 4'b0110;
  localparam logic [3:0] OP_MOV   = 4'b0111;
  localparam logic [3:0] OP_MVN   = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1001;
  localparam logic [3:0] OP_UMULL = 4'b1010;
  localparam logic [3:0] OP_SMULL = 4'b1011;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_UDIV  = 4'b1100;
  localparam logic [3:0] OP_SDIV  = 4'b1101;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t state_q, state_d;

  function automatic logic is_multi(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL) ||
           (op == OP_UDIV) || (op == OP_SDIV);
`else
    return (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL);
`endif
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == OP_SMULL) || (op == OP_SDIV);
`else
    return (op == OP_SMULL);
`endif
  endfunction

  // Latched operation context
  logic [3:0]       op_q;
  logic             cf_q;
  logic             neg_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] mq_q;
  logic [CW-1:0]    cnt_q;
`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] a_q;
  logic             bz_q;
  logic             rneg_q;
`endif

  // Output registers
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] hi_q;
  logic [3:0]       flags_q;
  logic             done_q;

  logic accept;
  assign accept = Start && (state_q != S_RUN);

  // Single-cycle datapath: adder operand selection, logic unit, flags
  logic [WIDTH-1:0] add_x, add_y, logic_res, sc_result;
  logic             add_cin, use_adder, sc_c, sc_v;
  logic [WIDTH:0]   add_sum;

  always_comb begin
    add_x     = Src_A;
    add_y     = Src_B;
    add_cin   = 1'b0;
    use_adder = 1'b0;
    case (ALUControl)
      OP_ADD: begin add_cin = isADC & C_Flag; use_adder = 1'b1; end
      OP_SUB: begin add_y = ~Src_B; add_cin = C_Flag; use_adder = 1'b1; end
      OP_RSB: begin add_x = Src_B; add_y = ~Src_A; add_cin = C_Flag; use_adder = 1'b1; end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

  // Logic ops; unused codes fall through to MOV behaviour
  always_comb begin
    logic_res = Src_B;
    case (ALUControl)
      OP_AND:  logic_res = Src_A & Src_B;
      OP_ORR:  logic_res = Src_A | Src_B;
      OP_EOR:  logic_res = Src_A ^ Src_B;
      OP_BIC:  logic_res = Src_A & ~Src_B;
      OP_MOV:  logic_res = Src_B;
      OP_MVN:  logic_res = ~Src_B;
      default: logic_res = Src_B;
    endcase
  end

  assign sc_result = use_adder ? add_sum[WIDTH-1:0] : logic_res;
  assign sc_c      = use_adder ? (isArithmeticOp ? add_sum[WIDTH] : Shifter_carryOut)
                               : (isArithmeticOp ? 1'b0 : Shifter_carryOut);
  assign sc_v      = use_adder && (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != add_x[WIDTH-1]);

  // Operand magnitudes for the iterative units
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = is_signed_op(ALUControl) & Src_A[WIDTH-1];
  assign b_neg = is_signed_op(ALUControl) & Src_B[WIDTH-1];
  assign a_mag = a_neg ? -Src_A : Src_A;
  assign b_mag = b_neg ? -Src_B : Src_B;

  // One iteration: shift-add multiply step, or restoring divide step
  logic [WIDTH:0]   mul_sum, acc_d;
  logic [WIDTH-1:0] mq_d;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   div_shift, div_trial;
`endif

  always_comb begin
    mul_sum = mq_q[0] ? (acc_q + {1'b0, b_q}) : acc_q;
    acc_d   = {1'b0, mul_sum[WIDTH:1]};
    mq_d    = {mul_sum[0], mq_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
    if ((op_q == OP_UDIV) || (op_q == OP_SDIV)) begin
      if (!div_trial[WIDTH]) begin
        acc_d = div_trial;
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = div_shift;
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Final result formatting, taken from the last iteration's next values so
  // the results register on the same edge that ends RUN
  logic [2*WIDTH-1:0] prod_raw, prod;
  logic [WIDTH-1:0]   fin_lo, fin_hi;
  logic [3:0]         fin_flags;
  logic               fin_n;

  always_comb begin
    prod_raw = {acc_d[WIDTH-1:0], mq_d};
    prod     = neg_q ? -prod_raw : prod_raw;
    fin_lo   = prod[WIDTH-1:0];
    fin_hi   = (op_q == OP_MUL) ? '0 : prod[2*WIDTH-1:WIDTH];
`ifdef ALU_DIV_EN
    if ((op_q == OP_UDIV) || (op_q == OP_SDIV)) begin
      if (bz_q) begin
        fin_lo = '0;
        fin_hi = a_q;
      end else begin
        fin_lo = neg_q  ? -mq_d : mq_d;
        fin_hi = rneg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
      end
    end
`endif
    fin_n     = ((op_q == OP_UMULL) || (op_q == OP_SMULL)) ? fin_hi[WIDTH-1] : fin_lo[WIDTH-1];
    fin_flags = {fin_n, ~|{fin_hi, fin_lo}, cf_q, 1'b0};
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: FIN is the Done cycle and accepts a new Start like IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FIN: state_d = (Start && is_multi(ALUControl)) ? S_RUN : S_IDLE;
      S_RUN:         if (cnt_q == LAST) state_d = S_FIN;
      default:       state_d = S_IDLE;
    endcase
  end

  // Operand latching, iteration state and result registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      op_q    <= '0;
      cf_q    <= 1'b0;
      neg_q   <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
`ifdef ALU_DIV_EN
      a_q     <= '0;
      bz_q    <= 1'b0;
      rneg_q  <= 1'b0;
`endif
      res_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (is_multi(ALUControl)) begin
          op_q   <= ALUControl;
          cf_q   <= C_Flag;
          neg_q  <= a_neg ^ b_neg;
          b_q    <= b_mag;
          acc_q  <= '0;
          mq_q   <= a_mag;
          cnt_q  <= '0;
`ifdef ALU_DIV_EN
          a_q    <= Src_A;
          bz_q   <= (Src_B == '0);
          rneg_q <= a_neg;
`endif
        end else begin
          res_q   <= sc_result;
          hi_q    <= '0;
          flags_q <= {sc_result[WIDTH-1], (sc_result == '0), sc_c, sc_v};
          done_q  <= 1'b1;
        end
      end else if (state_q == S_RUN) begin
        acc_q <= acc_d;
        mq_q  <= mq_d;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          res_q   <= fin_lo;
          hi_q    <= fin_hi;
          flags_q <= fin_flags;
          done_q  <= 1'b1;
          cnt_q   <= '0;
        end
      end
    end
  end

  assign Busy        = (state_q == S_RUN);
  assign Done        = done_q;
  assign ALUResult   = res_q;
  assign ALUResultHi = hi_q;
  assign ALUFlags    = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a WIDTH=32 instance and a WIDTH=8 instance.
// Divide vectors run when ALU_DIV_EN is defined; otherwise 1100 is checked as unused.
module tb_seq_alu;

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                         OP_EOR = 4'b0100, OP_RSB = 4'b0101, OP_MVN = 4'b1000,
                         OP_MUL = 4'b1001, OP_UMULL = 4'b1010, OP_SMULL = 4'b1011,
                         OP_UDIV = 4'b1100, OP_SDIV = 4'b1101, OP_U14 = 4'b1110;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESETn;

  logic        start, cf, ar, adc, sh;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] res, hi;
  logic [3:0]  flags;

  logic        start8, cf8, ar8, adc8, sh8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  res8, hi8;
  logic [3:0]  flags8;

  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(32)) dut (
    .CLK(CLK), .RESETn(RESETn), .Start(start), .ALUControl(op),
    .Src_A(a), .Src_B(b), .C_Flag(cf), .isArithmeticOp(ar), .isADC(adc),
    .Shifter_carryOut(sh), .Busy(busy), .Done(done), .ALUResult(res),
    .ALUResultHi(hi), .ALUFlags(flags)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RESETn(RESETn), .Start(start8), .ALUControl(op8),
    .Src_A(a8), .Src_B(b8), .C_Flag(cf8), .isArithmeticOp(ar8), .isADC(adc8),
    .Shifter_carryOut(sh8), .Busy(busy8), .Done(done8), .ALUResult(res8),
    .ALUResultHi(hi8), .ALUFlags(flags8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start is driven for one cycle; returns #1 after the edge that samples it
  task automatic launch(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic c, input logic r, input logic d, input logic s);
    @(negedge CLK);
    op = o; a = av; b = bv; cf = c; ar = r; adc = d; sh = s; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic launch8(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                         input logic c, input logic r, input logic d, input logic s);
    @(negedge CLK);
    op8 = o; a8 = av; b8 = bv; cf8 = c; ar8 = r; adc8 = d; sh8 = s; start8 = 1'b1;
    @(posedge CLK); #1;
    start8 = 1'b0;
  endtask

  // Cycles from the sampling edge to Done, with a bounded wait
  task automatic wait_done(input bit w8, input int lat0, output int lat, output int nbusy);
    lat = lat0;
    nbusy = 0;
    while (((w8 ? done8 : done) !== 1'b1) && lat < 200) begin
      if ((w8 ? busy8 : busy) === 1'b1) nbusy++;
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  int lat, nb, ndone;

  initial begin
    RESETn = 1'b0;
    start = 0; op = '0; a = '0; b = '0; cf = 0; ar = 0; adc = 0; sh = 0;
    start8 = 0; op8 = '0; a8 = '0; b8 = '0; cf8 = 0; ar8 = 0; adc8 = 0; sh8 = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res, 0);
    chk("rst_hi", hi, 0);
    chk("rst_flags", flags, 0);
    chk("rst8_res", {busy8, done8, res8, hi8, flags8}, 0);
    @(negedge CLK); RESETn = 1'b1;
    @(posedge CLK); #1;
    chk("idle_done", done, 0);

    // ADD overflow
    launch(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1, 0, 0);
    chk("add_done", done, 1);
    chk("add_busy", busy, 0);
    chk("add_res", res, 32'h8000_0000);
    chk("add_flags", flags, 4'b1001);
    @(posedge CLK); #1;
    chk("add_done_pulse", done, 0);
    chk("add_res_hold", res, 32'h8000_0000);

    // SBC with and without carry-in
    launch(OP_SUB, 32'd5, 32'd5, 1, 1, 0, 0);
    chk("sbc1_res", res, 32'h0);
    chk("sbc1_flags", flags, 4'b0110);
    launch(OP_SUB, 32'd5, 32'd5, 0, 1, 0, 0);
    chk("sbc0_res", res, 32'hFFFF_FFFF);
    chk("sbc0_flags", flags, 4'b1000);

    // Logic ops and reverse subtract
    launch(OP_EOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 0, 1);
    chk("eor_res", res, 32'h0FF0_0FF0);
    chk("eor_flags", flags, 4'b0010);
    launch(OP_AND, 32'h0000_000F, 32'h0000_00F0, 0, 1, 0, 1);
    chk("and_res", res, 32'h0);
    chk("and_flags", flags, 4'b0100);
    launch(OP_RSB, 32'd3, 32'd10, 1, 1, 0, 0);
    chk("rsb_res", res, 32'd7);
    chk("rsb_flags", flags, 4'b0010);
    launch(OP_MVN, 32'h1234_5678, 32'h0, 0, 0, 0, 0);
    chk("mvn_res", res, 32'hFFFF_FFFF);
    chk("mvn_flags", flags, 4'b1000);
    launch(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 1, 0);
    chk("adc_res", res, 32'h1);
    chk("adc_flags", flags, 4'b0010);

    // UMULL; operands changed after Start must not matter
    launch(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 0);
    a = '0; b = '0; cf = 0;
    chk("umull_busy0", busy, 1);
    wait_done(0, 1, lat, nb);
    chk("umull_lat", lat, 33);
    chk("umull_nbusy", nb, 32);
    chk("umull_busy_at_done", busy, 0);
    chk("umull_hi", hi, 32'hFFFF_FFFE);
    chk("umull_lo", res, 32'h0000_0001);
    chk("umull_flags", flags, 4'b1010);

    // MUL with a Start pulse while busy (ignored)
    launch(OP_MUL, 32'd1234, 32'd5678, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    op = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("mul_ignore_busy", busy, 1);
    chk("mul_ignore_done", done, 0);
    wait_done(0, 4, lat, nb);
    chk("mul_lat", lat, 33);
    chk("mul_lo", res, 32'h006A_E9BC);
    chk("mul_hi", hi, 32'h0);
    chk("mul_flags", flags, 4'b0000);
    @(posedge CLK); #1;
    chk("mul_no_queue_done", done, 0);
    chk("mul_no_queue_busy", busy, 0);

    // SMULL, then back-to-back Start in the Done cycle
    launch(OP_SMULL, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, 0);
    wait_done(0, 1, lat, nb);
    chk("smull_lat", lat, 33);
    chk("smull_hi", hi, 32'hFFFF_FFFF);
    chk("smull_lo", res, 32'hFFFF_FFF1);
    chk("smull_flags", flags, 4'b1000);
    launch(OP_ADD, 32'd2, 32'd3, 0, 1, 0, 0);
    chk("b2b_done", done, 1);
    chk("b2b_res", res, 32'd5);
    chk("b2b_hi", hi, 32'd0);

`ifdef ALU_DIV_EN
    launch(OP_SDIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
    wait_done(0, 1, lat, nb);
    chk("sdiv_lat", lat, 33);
    chk("sdiv_q", res, 32'hFFFF_FFFD);
    chk("sdiv_r", hi, 32'hFFFF_FFFF);
    launch(OP_SDIV, 32'd10, 32'd0, 0, 0, 0, 0);
    wait_done(0, 1, lat, nb);
    chk("div0_q", res, 32'h0);
    chk("div0_r", hi, 32'd10);
    launch(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    wait_done(0, 1, lat, nb);
    chk("divmin_q", res, 32'h8000_0000);
    chk("divmin_r", hi, 32'h0);
    launch(OP_UDIV, 32'd100, 32'd7, 0, 0, 0, 0);
    wait_done(0, 1, lat, nb);
    chk("udiv_q", res, 32'd14);
    chk("udiv_r", hi, 32'd2);
`else
    launch(OP_UDIV, 32'h1, 32'hDEAD_BEEF, 0, 0, 0, 1);
    chk("unused12_done", done, 1);
    chk("unused12_busy", busy, 0);
    chk("unused12_res", res, 32'hDEAD_BEEF);
    chk("unused12_hi", hi, 32'h0);
    chk("unused12_flags", flags, 4'b1010);
`endif
    launch(OP_U14, 32'h5, 32'h0, 0, 1, 0, 1);
    chk("unused14_res", res, 32'h0);
    chk("unused14_flags", flags, 4'b0100);

    // WIDTH=8 instance
    launch8(OP_SMULL, 8'h80, 8'h80, 0, 0, 0, 0);
    wait_done(1, 1, lat, nb);
    chk("w8_smull_lat", lat, 9);
    chk("w8_smull_nbusy", nb, 8);
    chk("w8_smull_hi", hi8, 8'h40);
    chk("w8_smull_lo", res8, 8'h00);
    chk("w8_smull_flags", flags8, 4'b0000);
`ifdef ALU_DIV_EN
    launch8(OP_UDIV, 8'd200, 8'd7, 0, 0, 0, 0);
    wait_done(1, 1, lat, nb);
    chk("w8_udiv_lat", lat, 9);
    chk("w8_udiv_q", res8, 8'h1C);
    chk("w8_udiv_r", hi8, 8'h04);
`else
    launch8(OP_UDIV, 8'h12, 8'hA5, 0, 0, 0, 1);
    chk("w8_unused_done", done8, 1);
    chk("w8_unused_busy", busy8, 0);
    chk("w8_unused_res", res8, 8'hA5);
    chk("w8_unused_flags", flags8, 4'b1010);
`endif

    // Reset during iteration 10 of a MUL
    launch(OP_MUL, 32'd3, 32'd4, 0, 0, 0, 0);
    repeat (9) @(posedge CLK);
    #1;
    chk("abort_busy_before", busy, 1);
    RESETn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", res, 0);
    chk("abort_hi", hi, 0);
    chk("abort_flags", flags, 0);
    @(negedge CLK);
    @(negedge CLK); RESETn = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
